// File: rtl/hud_pkg.sv
// Shared types, segment codes and width helpers for the HUD turn controller.
package hud_pkg;

    localparam int unsigned PLAYER_W  = 4;
    localparam int unsigned SCORE_W   = 7;
    localparam int unsigned TIMER_W   = 7;
    localparam int unsigned SCORE_MAX = 99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } hud_state_t;

    // Active-low segment patterns, bit 0 = segment a.
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit codes beyond 0-9 understood by hud_seg7.
    localparam logic [3:0] DIG_P     = 4'hA;
    localparam logic [3:0] DIG_DASH  = 4'hE;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Digit code to active-low segment pattern.
    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        case (code)
            4'd0:     return 7'h40;
            4'd1:     return 7'h79;
            4'd2:     return 7'h24;
            4'd3:     return 7'h30;
            4'd4:     return 7'h19;
            4'd5:     return 7'h12;
            4'd6:     return 7'h02;
            4'd7:     return 7'h78;
            4'd8:     return 7'h00;
            4'd9:     return 7'h10;
            DIG_P:    return SEG_P;
            DIG_DASH: return SEG_DASH;
            default:  return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/hud_seg7.sv
// Single-digit decoder: 4-bit code to active-low seven-segment pattern.
module hud_seg7
    import hud_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    // Pure lookup, registered by the parent.
    always_comb begin
        seg_c = seg_encode(digit);
    end

endmodule

// File: rtl/hud_turn_controller.sv
// HUD controller: player rotation, scores, turn countdown and six HEX displays.
// Optional macro HUD_TIMER_BLINK_EN blinks the timer digits in the last 3 seconds.
module hud_turn_controller
    import hud_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned TURN_SECONDS = 15,
    parameter int unsigned CLK_HZ       = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                match,
    input  logic                miss,
    input  logic                game_over,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [PLAYER_W-1:0] cur_player,
    output logic [PLAYER_W-1:0] winner,
    output logic                timeout
);

    localparam int unsigned        PRE_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX     = PRE_W'(CLK_HZ - 1);
    localparam logic [TIMER_W-1:0] TURN_RELOAD = TIMER_W'(TURN_SECONDS);
    localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
`ifdef HUD_TIMER_BLINK_EN
    localparam logic [PRE_W-1:0]   PRE_HALF    = PRE_W'(CLK_HZ / 2);
`endif

    hud_state_t          state_q, state_d;
    logic [PLAYER_W-1:0] cur_q, cur_d, winner_q, winner_d, best_c, disp_player;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [SCORE_W-1:0]  score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]  score_d [NUM_PLAYERS];
    logic [SCORE_W-1:0]  best_score, disp_score;
    logic                timeout_q, timeout_d, sec_tick;
    logic [3:0]          dig   [6];
    logic [6:0]          seg_c [6];
    logic [6:0]          hex_q [6];

    // Winner scan: highest score, ties resolved to the lowest index.
    always_comb begin
        best_c     = '0;
        best_score = score_q[0];
        for (int i = 1; i < int'(NUM_PLAYERS); i++) begin
            if (score_q[i] > best_score) begin
                best_score = score_q[i];
                best_c     = PLAYER_W'(i);
            end
        end
    end

    // Next-state logic; only the highest-priority event acts in PLAY.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        winner_d  = winner_q;
        timer_d   = timer_q;
        pre_d     = pre_q;
        timeout_d = 1'b0;
        for (int i = 0; i < int'(NUM_PLAYERS); i++) score_d[i] = score_q[i];
        sec_tick  = (pre_q == PRE_MAX);

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d  = PLAY;
                    cur_d    = '0;
                    winner_d = '0;
                    timer_d  = TURN_RELOAD;
                    pre_d    = '0;
                    for (int i = 0; i < int'(NUM_PLAYERS); i++) score_d[i] = '0;
                end
            end
            PLAY: begin
                if (game_over) begin
                    state_d  = OVER;
                    winner_d = best_c;
                end else if (match) begin
                    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                        if (PLAYER_W'(i) == cur_q && score_q[i] != SCORE_W'(SCORE_MAX))
                            score_d[i] = score_q[i] + SCORE_W'(1);
                    end
                    timer_d = TURN_RELOAD;
                    pre_d   = '0;
                end else if (miss || (sec_tick && timer_q == TIMER_W'(1))) begin
                    cur_d     = (cur_q == LAST_PLAYER) ? '0 : cur_q + PLAYER_W'(1);
                    timer_d   = TURN_RELOAD;
                    pre_d     = '0;
                    timeout_d = !miss;
                end else if (sec_tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                    pre_d   = '0;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display digit selection from the current (registered) game state.
    always_comb begin
        disp_player = (state_q == OVER) ? winner_q : cur_q;
        disp_score  = '0;
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (PLAYER_W'(i) == disp_player) disp_score = score_q[i];
        end
        dig[5] = DIG_P;
        dig[4] = disp_player + PLAYER_W'(1);
        dig[1] = 4'(disp_score / SCORE_W'(10));
        dig[0] = 4'(disp_score % SCORE_W'(10));
        case (state_q)
            IDLE: begin
                dig[3] = DIG_BLANK;
                dig[2] = DIG_BLANK;
            end
            OVER: begin
                dig[3] = DIG_DASH;
                dig[2] = DIG_DASH;
            end
            default: begin
                dig[3] = 4'(timer_q / TIMER_W'(10));
                dig[2] = 4'(timer_q % TIMER_W'(10));
`ifdef HUD_TIMER_BLINK_EN
                if (timer_q <= TIMER_W'(3) && pre_q >= PRE_HALF) begin
                    dig[3] = DIG_BLANK;
                    dig[2] = DIG_BLANK;
                end
`endif
            end
        endcase
    end

    for (genvar g = 0; g < 6; g++) begin : g_seg
        hud_seg7 u_seg7 (
            .digit (dig[g]),
            .seg_c (seg_c[g])
        );
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            winner_q  <= '0;
            timer_q   <= TURN_RELOAD;
            pre_q     <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < int'(NUM_PLAYERS); i++) score_q[i] <= '0;
            hex_q[5]  <= SEG_P;
            hex_q[4]  <= seg_encode(4'd1);
            hex_q[3]  <= SEG_BLANK;
            hex_q[2]  <= SEG_BLANK;
            hex_q[1]  <= seg_encode(4'd0);
            hex_q[0]  <= seg_encode(4'd0);
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            winner_q  <= winner_d;
            timer_q   <= timer_d;
            pre_q     <= pre_d;
            timeout_q <= timeout_d;
            for (int i = 0; i < int'(NUM_PLAYERS); i++) score_q[i] <= score_d[i];
            for (int i = 0; i < 6; i++) hex_q[i] <= seg_c[i];
        end
    end

    assign HEX0       = hex_q[0];
    assign HEX1       = hex_q[1];
    assign HEX2       = hex_q[2];
    assign HEX3       = hex_q[3];
    assign HEX4       = hex_q[4];
    assign HEX5       = hex_q[5];
    assign cur_player = cur_q;
    assign winner     = winner_q;
    assign timeout    = timeout_q;

endmodule
